// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch and data ports.
// Optional fetch anti-starvation guard: define UNIFIED_MEM_ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_param_check
    $error("unified_mem_arbiter: MEM_LAT or STARVE_MAX out of range");
  end

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              owner_data;
  logic              owner_we;
  logic              cancel;
  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              issue_ready;
  logic              issue;
  logic              force_fetch;
  logic              data_wins;
  logic              mem_done;
  logic              cancel_now;

  // Issuing is blocked while reset is held so every output reads 0 during reset.
  assign issue_ready = (state == S_IDLE) || (state == S_RESP);
  assign issue       = rst_i && issue_ready && (if_req_i || d_req_i);

`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_cnt;

  assign force_fetch = (starve_cnt == STARVE_LIM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= 3'd0;
    end else if (issue) begin
      if (!data_wins) begin
        starve_cnt <= 3'd0;
      end else if (if_req_i && (starve_cnt != 3'd7)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  assign data_wins = d_req_i && !(force_fetch && if_req_i);
  assign if_gnt_o  = issue && !data_wins;
  assign d_gnt_o   = issue && data_wins;
  assign busy_o    = (state == S_WAIT) || ((state == S_RESP) && issue);

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (issue) begin
      mem_en_o = 1'b1;
      if (data_wins) begin
        mem_we_o    = d_we_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end else begin
        mem_addr_o = if_addr_i;
      end
    end
  end

  // A flush arriving on the same cycle the read data lands still cancels the fetch.
  assign mem_done   = (state == S_WAIT) && (cnt == 4'd1);
  assign cancel_now = cancel || (!owner_data && if_flush_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      owner_data <= 1'b0;
      owner_we   <= 1'b0;
      cancel     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if (issue) begin
            state      <= S_WAIT;
            cnt        <= 4'(MEM_LAT);
            owner_data <= data_wins;
            owner_we   <= data_wins && d_we_i;
            cancel     <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (!owner_data && if_flush_i) begin
            cancel <= 1'b1;
          end
          if (mem_done) begin
            state <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= mem_done && !owner_data && !cancel_now;
      d_rvalid_q  <= mem_done && owner_data;
      if (mem_done && !owner_data && !cancel_now) begin
        if_rdata_q <= mem_rdata_i;
      end
      if (mem_done && owner_data && !owner_we) begin
        d_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed-vector bench for unified_mem_arbiter (MEM_LAT=2); each applyStimulus call is one clock cycle.
module tb_unified_mem_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int vectors = 0;
  int errors  = 0;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
  task automatic applyStimulus(input logic rst, input logic ifr, input logic [31:0] ifa,
                               input logic flush, input logic dr, input logic dwe,
                               input logic [31:0] da, input logic [31:0] dwd,
                               input logic [31:0] mrd);
    @(negedge clk_i);
    rst_i       = rst;
    if_req_i    = ifr;
    if_addr_i   = ifa;
    if_flush_i  = flush;
    d_req_i     = dr;
    d_we_i      = dwe;
    d_addr_i    = da;
    d_wdata_i   = dwd;
    mem_rdata_i = mrd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0;

    // Reset state, with requests present while reset is held
    applyStimulus(0, 1, 32'h0, 0, 1, 0, 32'h10, 32'h0, 32'h0);
    checkOutput("rst_if_gnt", 32'(if_gnt_o), 32'h0);
    checkOutput("rst_d_gnt", 32'(d_gnt_o), 32'h0);
    checkOutput("rst_mem_en", 32'(mem_en_o), 32'h0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    checkOutput("rst_if_rdata", if_rdata_o, 32'h0);
    checkOutput("rst_d_rdata", d_rdata_o, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

    // Reset in the middle of a load
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h10, 32'h0, 32'h0);
    checkOutput("rml_d_gnt_T", 32'(d_gnt_o), 32'h1);
    checkOutput("rml_mem_addr_T", mem_addr_o, 32'h10);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("rml_busy_T1", 32'(busy_o), 32'h0);
    checkOutput("rml_mem_en_T1", 32'(mem_en_o), 32'h0);
    checkOutput("rml_d_rvalid_T1", 32'(d_rvalid_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF);
    checkOutput("rml_busy_T2", 32'(busy_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("rml_d_rvalid_T3", 32'(d_rvalid_o), 32'h0);
    checkOutput("rml_d_rdata_T3", d_rdata_o, 32'h0);

    // Single fetch
    applyStimulus(1, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("sf_if_gnt_T", 32'(if_gnt_o), 32'h1);
    checkOutput("sf_d_gnt_T", 32'(d_gnt_o), 32'h0);
    checkOutput("sf_mem_en_T", 32'(mem_en_o), 32'h1);
    checkOutput("sf_mem_we_T", 32'(mem_we_o), 32'h0);
    checkOutput("sf_mem_addr_T", mem_addr_o, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("sf_busy_T1", 32'(busy_o), 32'h1);
    checkOutput("sf_mem_en_T1", 32'(mem_en_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h2002000A);
    checkOutput("sf_if_rvalid_T2", 32'(if_rvalid_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("sf_if_rvalid_T3", 32'(if_rvalid_o), 32'h1);
    checkOutput("sf_if_rdata_T3", if_rdata_o, 32'h2002000A);
    checkOutput("sf_busy_T3", 32'(busy_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("sf_if_rvalid_T4", 32'(if_rvalid_o), 32'h0);
    checkOutput("sf_if_rdata_T4", if_rdata_o, 32'h2002000A);

    // Contention: store beats fetch, fetch follows at T+3
    applyStimulus(1, 1, 32'h100, 0, 1, 1, 32'h40, 32'h55, 32'h0);
    checkOutput("ct_d_gnt_T", 32'(d_gnt_o), 32'h1);
    checkOutput("ct_if_gnt_T", 32'(if_gnt_o), 32'h0);
    checkOutput("ct_mem_we_T", 32'(mem_we_o), 32'h1);
    checkOutput("ct_mem_addr_T", mem_addr_o, 32'h40);
    checkOutput("ct_mem_wdata_T", mem_wdata_o, 32'h55);
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("ct_if_gnt_T1", 32'(if_gnt_o), 32'h0);
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 32'h11111111);
    checkOutput("ct_if_gnt_T2", 32'(if_gnt_o), 32'h0);
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("ct_d_rvalid_T3", 32'(d_rvalid_o), 32'h1);
    checkOutput("ct_d_rdata_T3", d_rdata_o, 32'h0);
    checkOutput("ct_if_gnt_T3", 32'(if_gnt_o), 32'h1);
    checkOutput("ct_mem_addr_T3", mem_addr_o, 32'h100);
    checkOutput("ct_busy_T3", 32'(busy_o), 32'h1);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("ct_d_rvalid_T4", 32'(d_rvalid_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("ct_if_rvalid_T6", 32'(if_rvalid_o), 32'h1);
    checkOutput("ct_if_rdata_T6", if_rdata_o, 32'hCAFEF00D);

    // Flush cancels an outstanding fetch; the next fetch issues at T+3
    applyStimulus(1, 1, 32'h200, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("fl_if_gnt_T", 32'(if_gnt_o), 32'h1);
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'hBADBAD00);
    checkOutput("fl_if_rvalid_T2", 32'(if_rvalid_o), 32'h0);
    applyStimulus(1, 1, 32'h204, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("fl_if_rvalid_T3", 32'(if_rvalid_o), 32'h0);
    checkOutput("fl_if_rdata_T3", if_rdata_o, 32'hCAFEF00D);
    checkOutput("fl_if_gnt_T3", 32'(if_gnt_o), 32'h1);
    checkOutput("fl_mem_addr_T3", mem_addr_o, 32'h204);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h12345678);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("fl_if_rvalid_T6", 32'(if_rvalid_o), 32'h1);
    checkOutput("fl_if_rdata_T6", if_rdata_o, 32'h12345678);

    // Back-to-back loads with d_req held
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h4, 32'h0, 32'h0);
    checkOutput("bb_d_gnt_T", 32'(d_gnt_o), 32'h1);
    checkOutput("bb_mem_addr_T", mem_addr_o, 32'h4);
    checkOutput("bb_busy_T", 32'(busy_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 1, 1, 0, 32'h8, 32'h0, 32'h0);
    checkOutput("bb_busy_T1", 32'(busy_o), 32'h1);
    checkOutput("bb_d_gnt_T1", 32'(d_gnt_o), 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h8, 32'h0, 32'hA0A0A0A0);
    checkOutput("bb_busy_T2", 32'(busy_o), 32'h1);
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h8, 32'h0, 32'h0);
    checkOutput("bb_d_rvalid_T3", 32'(d_rvalid_o), 32'h1);
    checkOutput("bb_d_rdata_T3", d_rdata_o, 32'hA0A0A0A0);
    checkOutput("bb_d_gnt_T3", 32'(d_gnt_o), 32'h1);
    checkOutput("bb_mem_addr_T3", mem_addr_o, 32'h8);
    checkOutput("bb_busy_T3", 32'(busy_o), 32'h1);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("bb_busy_T4", 32'(busy_o), 32'h1);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'hB0B0B0B0);
    checkOutput("bb_busy_T5", 32'(busy_o), 32'h1);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("bb_d_rvalid_T6", 32'(d_rvalid_o), 32'h1);
    checkOutput("bb_d_rdata_T6", d_rdata_o, 32'hB0B0B0B0);
    checkOutput("bb_busy_T6", 32'(busy_o), 32'h0);
    checkOutput("bb_if_rdata_T6", if_rdata_o, 32'h12345678);

    // Both requesters held for five issue slots
    for (int i = 0; i < 5; i++) begin
      logic exp_fetch;
`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
      exp_fetch = (i == 4);
`else
      exp_fetch = 1'b0;
`endif
      applyStimulus(1, 1, 32'h300, 0, 1, 0, 32'h80, 32'h0, 32'h0);
      checkOutput($sformatf("sg_if_gnt_%0d", i), 32'(if_gnt_o), 32'(exp_fetch));
      checkOutput($sformatf("sg_d_gnt_%0d", i), 32'(d_gnt_o), 32'(!exp_fetch));
      applyStimulus(1, 1, 32'h300, 0, 1, 0, 32'h80, 32'h0, 32'h0);
      applyStimulus(1, 1, 32'h300, 0, 1, 0, 32'h80, 32'h0, 32'h0);
    end
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("sg_busy_drain", 32'(busy_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Sits between the IF/MEM stages and a unified memory macro.
- Arbitrates one transaction at a time, sequences the memory latency, and returns responses to the owning requester.
- Deasserted grants are the stage stall source for the pipeline hazard logic.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from memory issue to valid mem_rdata_i; legal range 1..15.
- STARVE_MAX, 4, consecutive lost fetch arbitrations before fetch is forced to win (used only with the optional feature).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request; level, held until granted.
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high.
- if_flush_i  in  1  cancels an outstanding fetch response.
- if_gnt_o  out  1  fetch issued this cycle.
- if_rvalid_o  out  1  fetch response valid, one-cycle pulse.
- if_rdata_o  out  DATA_W  fetch data, held until the next fetch response.
- d_req_i  in  1  data request; level, held until granted.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_gnt_o  out  1  data issued this cycle.
- d_rvalid_o  out  1  load data valid, or store acknowledge; one-cycle pulse.
- d_rdata_o  out  DATA_W  load data, held until the next load response.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after the issue cycle.
- busy_o  out  1  a transaction is outstanding.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - Counter and starve count cleared; owner cleared.
  - All outputs 0, including the rdata hold registers.
  - An in-flight transaction is abandoned: no rvalid, late mem_rdata_i ignored.
- FSM states:
  - IDLE: no transaction.
  - WAIT: counting latency.
  - RESP: response cycle.
  - Issue-ready = IDLE or RESP.
- Issue cycle T (issue-ready and any request present):
  - Winner selected combinationally; its gnt asserted.
  - mem_en_o=1; mem_addr_o/mem_we_o/mem_wdata_o driven from the winner's inputs in the same cycle.
  - mem_we_o=0 for fetch.
  - Owner and a cancel flag are latched; counter loaded with MEM_LAT; next state WAIT.
- Outside an issue cycle: mem_en_o=0, mem_we_o=0, mem_addr_o/mem_wdata_o=0, both gnts 0.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle mem_rdata_i is valid (T+MEM_LAT), it is captured into the owner's rdata register; next state RESP.
- RESP (cycle T+MEM_LAT+1):
  - Owner's rvalid pulses for one cycle; rdata_o already updated.
  - Store: d_rvalid_o pulses; d_rdata_o is unchanged.
  - Next state is WAIT if a new issue happens this cycle, else IDLE.
- Timing: latency issue-to-rvalid = MEM_LAT+1 cycles; peak throughput one access per MEM_LAT+1 cycles.
- Priority: data beats fetch when both request in an issue-ready cycle (strict, without the optional feature).
- if_flush_i:
  - Sampled every cycle from issue cycle T+1 through the cycle mem_rdata_i is valid (T+MEM_LAT); if asserted then and the owner is fetch, the cancel flag is set.
  - A cancelled fetch still completes its memory timing, but if_rvalid_o stays 0 and if_rdata_o is not updated.
  - if_flush_i has no effect on a data transaction or when idle.
  - if_flush_i in the issue cycle itself does not cancel; the requester drops if_req_i instead.
- busy_o = 1 in WAIT, and in RESP only when a new issue occurs.
- Counter width = 4 bits; no wrap is possible within the legal MEM_LAT range.

Optional Feature:
- Macro: UNIFIED_MEM_ARB_STARVE_GUARD_EN.
- When defined:
  - A 3-bit saturating starve count increments on each issue cycle where if_req_i=1 but data wins.
  - It clears on any fetch grant.
  - When the count equals STARVE_MAX, fetch wins the next contested issue.
- When undefined: strict data priority; no counter is present.

Test Plan:
- Reset mid-load (MEM_LAT=2): d_req load addr 0x10 granted at T, rst_i low at T+1 → all outputs 0; no d_rvalid at T+3 even with mem_rdata_i=0xDEADBEEF.
- Single fetch: if_req addr 0x0, mem_rdata_i=0x2002000A at T+2 → if_gnt_o=1 at T, mem_en_o=1/mem_we_o=0/mem_addr_o=0x0 at T, if_rvalid_o=1 with if_rdata_o=0x2002000A at T+3.
- Contention: if_req and d_req (store, addr 0x40, data 0x55) both high at T → d_gnt_o at T with mem_we_o=1/mem_wdata_o=0x55; d_rvalid_o at T+3; if_gnt_o at T+3; if_rvalid_o at T+6.
- Flush: fetch granted at T, if_flush_i=1 at T+1 → if_rvalid_o stays 0 through T+3, if_rdata_o unchanged, next fetch grantable at T+3.
- Back-to-back loads: d_req held high with addresses 0x4 then 0x8 → d_gnt_o at T and T+3; d_rvalid_o at T+3 and T+6; busy_o high from T+1 through T+5.
- Starve guard (macro defined, STARVE_MAX=4): d_req and if_req held continuously → first four issues go to data, fifth issue grants fetch; macro undefined → fetch never granted while d_req is held high.
